// File: rtl/cpu_step_ctrl.sv
// Run/step/breakpoint sequencer that gates the clock enable of a multicycle CPU.
// Latency: cpu_en/instr_done/bp_hit are combinational from state; mode/step_req act on the next edge.
// No backpressure: step_req is a single-cycle pulse and is dropped unless IDLE or BREAK sees it.
module cpu_step_ctrl #(
    parameter int CYCLES_PER_INSTR = 7,
    parameter int ADDR_W           = 11,
    parameter int NUM_BP           = 2
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [1:0]                                  mode,
    input  logic                                        step_req,
    input  logic [ADDR_W-1:0]                           pc,
    input  logic [NUM_BP-1:0]                           bp_en,
    input  logic [NUM_BP*ADDR_W-1:0]                    bp_addr,
    output logic                                        cpu_en,
    output logic                                        instr_done,
    output logic                                        halted,
    output logic                                        bp_hit,
    output logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] bp_idx,
    output logic [$clog2(CYCLES_PER_INSTR)-1:0]         phase,
    output logic [31:0]                                 instr_count
);

    localparam int PH_W  = $clog2(CYCLES_PER_INSTR);
    localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(CYCLES_PER_INSTR - 1);

    localparam logic [1:0] M_HALT   = 2'b00;
    localparam logic [1:0] M_RUN    = 2'b10;
    localparam logic [1:0] M_RUN_BP = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STEP  = 2'd1,
        S_RUN   = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [31:0]       count_q, count_d;
    logic              skip_q, skip_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              any_match;
    logic [IDX_W-1:0]  match_idx;
    logic              gate_block;

    // Breakpoint compare: scan high-to-low so the lowest matching channel wins.
    always_comb begin
        any_match = 1'b0;
        match_idx = '0;
        for (int k = NUM_BP - 1; k >= 0; k--) begin
            if (bp_en[k] && (bp_addr[k*ADDR_W +: ADDR_W] == pc)) begin
                any_match = 1'b1;
                match_idx = IDX_W'(k);
            end
        end
    end

    // Next-state and output decode; the start gate only looks at instruction boundaries.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        skip_d     = skip_q;
        phase_d    = phase_q;
        count_d    = count_q;

        gate_block = (state_q == S_RUN) && (mode == M_RUN_BP) && (phase_q == '0)
                     && !skip_q && any_match;
        cpu_en     = ((state_q == S_STEP) || (state_q == S_RUN)) && !gate_block;
        instr_done = cpu_en && (phase_q == LAST_PH);
        halted     = (state_q == S_IDLE) || (state_q == S_BREAK);
        bp_hit     = (state_q == S_BREAK);

        if (cpu_en) begin
            phase_d = (phase_q == LAST_PH) ? '0 : phase_q + PH_W'(1);
        end
        if (instr_done) begin
            count_d = count_q + 32'd1;
            skip_d  = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (step_req) begin
                    state_d = S_STEP;
                end else if (mode[1]) begin
                    state_d = S_RUN;
                end
            end
            S_STEP: begin
                if (instr_done) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (gate_block) begin
                    state_d = S_BREAK;
                    idx_d   = match_idx;
                end else if (instr_done && !mode[1]) begin
                    state_d = S_IDLE;
                end
            end
            S_BREAK: begin
                // A step request beats any run mode, so RUN_BP+step executes exactly one instruction.
                if (step_req) begin
                    state_d = S_STEP;
                end else if (mode == M_RUN) begin
                    state_d = S_RUN;
                end else if (mode == M_HALT) begin
                    state_d = S_IDLE;
                end
                if (state_d != S_BREAK) begin
                    skip_d = 1'b1;
                    idx_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, phase, counter and breakpoint bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            count_q <= '0;
            skip_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            count_q <= count_d;
            skip_q  <= skip_d;
            idx_q   <= idx_d;
        end
    end

    assign bp_idx      = idx_q;
    assign phase       = phase_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: cycle model for the default build plus a small 4-channel/5-cycle build.
// Latency: model outputs are compared every negedge; inputs are driven 1 time unit after posedge.
// No backpressure: every wait is bounded by a cycle budget.
module tb_cpu_step_ctrl;

    localparam int CPI    = 7;
    localparam int ADDR_W = 11;
    localparam int NUM_BP = 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [1:0]               mode = 2'b00;
    logic                     step_req = 1'b0;
    logic [ADDR_W-1:0]        pc = '0;
    logic [NUM_BP-1:0]        bp_en = '0;
    logic [NUM_BP*ADDR_W-1:0] bp_addr = '0;
    logic                     cpu_en, instr_done, halted, bp_hit;
    logic [0:0]               bp_idx;
    logic [2:0]               phase;
    logic [31:0]              instr_count;

    logic [1:0]               mode2 = 2'b00;
    logic                     step2 = 1'b0;
    logic [ADDR_W-1:0]        pc2 = '0;
    logic [3:0]               bp_en2 = '0;
    logic [4*ADDR_W-1:0]      bp_addr2 = '0;
    logic                     cpu_en2, done2, halted2, bp_hit2;
    logic [1:0]               bp_idx2;
    logic [2:0]               phase2;
    logic [31:0]              count2;

    int errors = 0;
    int checks = 0;

    cpu_step_ctrl dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .step_req(step_req), .pc(pc),
        .bp_en(bp_en), .bp_addr(bp_addr), .cpu_en(cpu_en), .instr_done(instr_done),
        .halted(halted), .bp_hit(bp_hit), .bp_idx(bp_idx), .phase(phase),
        .instr_count(instr_count)
    );

    cpu_step_ctrl #(.CYCLES_PER_INSTR(5), .ADDR_W(ADDR_W), .NUM_BP(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode2), .step_req(step2), .pc(pc2),
        .bp_en(bp_en2), .bp_addr(bp_addr2), .cpu_en(cpu_en2), .instr_done(done2),
        .halted(halted2), .bp_hit(bp_hit2), .bp_idx(bp_idx2), .phase(phase2),
        .instr_count(count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model state: act 0 = stopped, 1 = one instruction, 2 = free running; brk marks a breakpoint stop.
    int          m_act = 0, m_ph = 0, m_idx = 0;
    bit          m_brk = 0, m_skip = 0;
    int unsigned m_cnt = 0;
    int          n_act = 0, n_ph = 0, n_idx = 0;
    bit          n_brk = 0, n_skip = 0;
    int unsigned n_cnt = 0;
    int          en_cnt = 0, done_cnt = 0, en2_cnt = 0, done2_cnt = 0;

    always @(negedge clk) begin
        bit hit, blk, en, dn;
        int hk;
        hit = 0;
        hk  = 0;
        for (int k = NUM_BP - 1; k >= 0; k--) begin
            if (bp_en[k] && bp_addr[k*ADDR_W +: ADDR_W] == pc) begin
                hit = 1;
                hk  = k;
            end
        end
        blk = (m_act == 2) && (mode == 2'b11) && (m_ph == 0) && !m_skip && hit;
        en  = (m_act != 0) && !blk;
        dn  = en && (m_ph == CPI - 1);

        chk("cpu_en", cpu_en, en);
        chk("instr_done", instr_done, dn);
        chk("halted", halted, m_act == 0);
        chk("bp_hit", bp_hit, m_brk);
        chk("bp_idx", bp_idx, m_idx);
        chk("phase", phase, m_ph);
        chk("instr_count", instr_count, m_cnt);

        en_cnt    += int'(cpu_en);
        done_cnt  += int'(instr_done);
        en2_cnt   += int'(cpu_en2);
        done2_cnt += int'(done2);

        n_act = m_act; n_ph = m_ph; n_idx = m_idx; n_brk = m_brk; n_skip = m_skip; n_cnt = m_cnt;
        if (en) n_ph = (m_ph + 1) % CPI;
        if (dn) begin
            n_cnt  = m_cnt + 1;
            n_skip = 0;
        end
        if (m_brk) begin
            if (step_req || mode == 2'b10 || mode == 2'b00) begin
                n_brk  = 0;
                n_skip = 1;
                n_idx  = 0;
                n_act  = step_req ? 1 : (mode == 2'b10 ? 2 : 0);
            end
        end else if (m_act == 0) begin
            if (step_req) n_act = 1;
            else if (mode[1]) n_act = 2;
        end else if (blk) begin
            n_act = 0;
            n_brk = 1;
            n_idx = hk;
        end else if (dn && (m_act == 1 || !mode[1])) begin
            n_act = 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_ph = 0; m_idx = 0; m_brk = 0; m_skip = 0; m_cnt = 0;
        end else begin
            m_act = n_act; m_ph = n_ph; m_idx = n_idx; m_brk = n_brk; m_skip = n_skip; m_cnt = n_cnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mode = 2'b00; step_req = 1'b0; pc = '0; bp_en = '0; bp_addr = '0;
        mode2 = 2'b00; step2 = 1'b0; pc2 = '0; bp_en2 = '0; bp_addr2 = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, dstart;
        #3;
        chk("reset_halted", halted, 1);
        chk("reset_cpu_en", cpu_en, 0);
        do_reset();

        // Single step in HALT: seven enabled cycles then stopped again.
        start = en_cnt;
        step_req = 1'b1; tick(); step_req = 1'b0;
        repeat (12) tick();
        chk("step_en_cycles", en_cnt - start, 7);
        chk("step_count", instr_count, 1);
        chk("step_halted", halted, 1);
        chk("step_phase", phase, 0);

        // Free run, stray step_req mid-run, HALT requested at phase 3 of the fifth instruction.
        do_reset();
        mode = 2'b10;
        start = en_cnt;
        for (int i = 0; i < 100 && !(instr_count == 4 && phase == 3); i++) begin
            step_req = (instr_count == 2 && phase == 1);
            tick();
        end
        step_req = 1'b0;
        chk("run_reached_ph3", (instr_count == 4 && phase == 3), 1);
        mode = 2'b00;
        repeat (20) tick();
        chk("run_en_cycles", en_cnt - start, 35);
        chk("run_count", instr_count, 5);
        chk("run_phase", phase, 0);
        chk("run_halted", halted, 1);

        // Breakpoint at pc 5 with pc advancing once per instruction.
        do_reset();
        bp_en = 2'b01;
        bp_addr = {11'd0, 11'd5};
        mode = 2'b11;
        for (int i = 0; i < 80 && !bp_hit; i++) begin
            tick();
            pc = ADDR_W'(m_cnt);
        end
        chk("bp_reached", bp_hit, 1);
        chk("bp_cpu_en", cpu_en, 0);
        chk("bp_idx0", bp_idx, 0);
        chk("bp_count", instr_count, 5);
        chk("bp_pc", pc, 5);

        // Step out of the break with RUN_BP still selected: one instruction, no re-break.
        start = en_cnt;
        step_req = 1'b1; tick(); step_req = 1'b0;
        for (int i = 0; i < 20 && instr_count != 6; i++) tick();
        chk("bpstep_en_cycles", en_cnt - start, 7);
        chk("bpstep_idle", halted, 1);
        chk("bpstep_no_hit", bp_hit, 0);
        mode = 2'b00;
        repeat (5) tick();
        chk("bpstep_stays", halted && !bp_hit, 1);

        // Resume by RUN, then back to RUN_BP on the same pc: skip lets it run once, then breaks again.
        do_reset();
        bp_en = 2'b01; bp_addr = {11'd0, 11'd5}; pc = 11'd5; mode = 2'b11;
        for (int i = 0; i < 10 && !bp_hit; i++) tick();
        chk("skip_first_break", bp_hit && instr_count == 0, 1);
        mode = 2'b10; tick(); mode = 2'b11;
        for (int i = 0; i < 20 && !bp_hit; i++) tick();
        chk("skip_rebreak", bp_hit, 1);
        chk("skip_count", instr_count, 1);

        // Two channels on address 9: lowest index wins; with channel 0 off, channel 1 reports.
        do_reset();
        bp_en = 2'b11; bp_addr = {11'd9, 11'd9}; pc = 11'd9; mode = 2'b11;
        for (int i = 0; i < 10 && !bp_hit; i++) tick();
        chk("dual_hit", bp_hit, 1);
        chk("dual_idx", bp_idx, 0);
        do_reset();
        bp_en = 2'b10; bp_addr = {11'd9, 11'd9}; pc = 11'd9; mode = 2'b11;
        for (int i = 0; i < 10 && !bp_hit; i++) tick();
        chk("ch1_hit", bp_hit, 1);
        chk("ch1_idx", bp_idx, 1);
        mode = 2'b00; tick();
        chk("leave_clears_hit", bp_hit, 0);
        chk("leave_clears_idx", bp_idx, 0);

        // Step and RUN together in IDLE: the step wins, one instruction then stop.
        do_reset();
        mode = 2'b10; step_req = 1'b1; tick(); step_req = 1'b0; mode = 2'b00;
        repeat (10) tick();
        chk("step_wins_count", instr_count, 1);
        chk("step_wins_halted", halted, 1);

        // Asynchronous reset at phase 4 of the second instruction.
        do_reset();
        mode = 2'b10;
        for (int i = 0; i < 40 && !(instr_count == 1 && phase == 4); i++) tick();
        chk("arst_reached_ph4", (instr_count == 1 && phase == 4), 1);
        dstart = done_cnt;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cpu_en", cpu_en, 0);
        chk("arst_done", instr_done, 0);
        chk("arst_halted", halted, 1);
        chk("arst_phase", phase, 0);
        chk("arst_count", instr_count, 0);
        chk("arst_bp_hit", bp_hit, 0);
        tick();
        chk("arst_no_done_pulse", done_cnt - dstart, 0);
        mode = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();

        // Five-cycle, four-channel build: single step, then a breakpoint on channel 3.
        do_reset();
        start = en2_cnt;
        dstart = done2_cnt;
        step2 = 1'b1; tick(); step2 = 1'b0;
        for (int p = 0; p < 5; p++) begin
            chk("b2_phase_seq", phase2, p);
            chk("b2_en_seq", cpu_en2, 1);
            chk("b2_done_seq", done2, p == 4);
            tick();
        end
        repeat (4) tick();
        chk("b2_en_cycles", en2_cnt - start, 5);
        chk("b2_done_pulses", done2_cnt - dstart, 1);
        chk("b2_count", count2, 1);
        chk("b2_halted", halted2, 1);
        chk("b2_phase", phase2, 0);
        bp_en2 = 4'b1000; bp_addr2 = {11'd7, 11'd0, 11'd0, 11'd0}; pc2 = 11'd7; mode2 = 2'b11;
        for (int i = 0; i < 10 && !bp_hit2; i++) tick();
        chk("b2_bp_hit", bp_hit2, 1);
        chk("b2_bp_idx", bp_idx2, 3);
        chk("b2_bp_cpu_en", cpu_en2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
